ttl_gate_bank: RTL and testbench



---
 rtl/ttl_pkg.sv | 43 ++++
 rtl/ttl_delay_line.sv | 103 ++++++++++
 rtl/ttl_gate_bank.sv | 65 ++++++
 tb/tb_ttl_gate_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// ttl_pkg: shared types and helpers for the TTL gate library.
//   gate_func_t    : selectable gate function
//   gate_eval      : evaluates a gate over an 8-bit input vector
//   gate_pad_val   : neutral fill value for unused vector bits
//   gate_reset_val : gate output for all-zero inputs (used as the reset value)
package ttl_pkg;

  localparam int unsigned MaxInputs = 8;

  typedef enum logic [2:0] {
    GATE_NOR,
    GATE_OR,
    GATE_NAND,
    GATE_AND,
    GATE_XOR,
    GATE_XNOR
  } gate_func_t;

  // Unused inputs are padded with a value that cannot change the result:
  // 1 for AND-type gates, 0 for OR-type and parity gates.
  function automatic logic gate_pad_val(gate_func_t func);
    return (func == GATE_AND) || (func == GATE_NAND);
  endfunction

  function automatic logic gate_eval(gate_func_t func, logic [MaxInputs-1:0] vec);
    logic r;
    case (func)
      GATE_NOR:  r = ~|vec;
      GATE_OR:   r = |vec;
      GATE_NAND: r = ~&vec;
      GATE_AND:  r = &vec;
      GATE_XOR:  r = ^vec;
      GATE_XNOR: r = ~^vec;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic gate_reset_val(gate_func_t func);
    return (func == GATE_NOR) || (func == GATE_NAND) || (func == GATE_XNOR);
  endfunction

endpackage

// File: rtl/ttl_delay_line.sv
// ttl_delay_line: one gate channel's timing path.
//   DELAY-stage ce-gated shift register, optional glitch filter, and registered
//   rise/fall pulse outputs. Optional filter enabled by `define TTL_GLITCH_FILTER_EN.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset (loads RESET_VAL everywhere)
//   ce    : clock enable for the pipeline and filter
//   raw   : combinational gate result for this channel
//   y     : delayed (and optionally filtered) gate output
//   rise  : one-cycle pulse, one cycle after y goes 0->1
//   fall  : one-cycle pulse, one cycle after y goes 1->0
module ttl_delay_line #(
  parameter int unsigned DELAY      = 1,
  parameter int unsigned FILTER_LEN = 2,
  parameter logic        RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic raw,
  output logic y,
  output logic rise,
  output logic fall
);

  if (DELAY < 1 || DELAY > 8) begin : g_bad_delay
    $error("ttl_delay_line: DELAY out of range 1..8");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
    $error("ttl_delay_line: FILTER_LEN out of range 1..15");
  end

  logic [DELAY-1:0] stage_q;
  logic [DELAY-1:0] stage_d;
  logic             y_cur;
  logic             y_prev_q;
  logic             rise_q;
  logic             fall_q;

  if (DELAY == 1) begin : g_one
    assign stage_d = raw;
  end else begin : g_multi
    assign stage_d = {stage_q[DELAY-2:0], raw};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= {DELAY{RESET_VAL}};
    end else if (ce) begin
      stage_q <= stage_d;
    end
  end

`ifdef TTL_GLITCH_FILTER_EN
  localparam logic [3:0] FilterLast = 4'(FILTER_LEN - 1);

  logic [3:0] cnt_q;
  logic       y_q;

  // Compare against the value entering the last stage so that the filter adds
  // exactly FILTER_LEN-1 ce edges of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q   <= RESET_VAL;
      cnt_q <= '0;
    end else if (ce) begin
      if (stage_d[DELAY-1] != y_q) begin
        if (cnt_q == FilterLast) begin
          y_q   <= ~y_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign y_cur = y_q;
`else
  assign y_cur = stage_q[DELAY-1];
`endif

  // Edge detect against last cycle's y; runs every clk so pulses never stretch
  // when ce is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_prev_q <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      y_prev_q <= y_cur;
      rise_q   <= y_cur & ~y_prev_q;
      fall_q   <= ~y_cur & y_prev_q;
    end
  end

  assign y    = y_cur;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/ttl_gate_bank.sv
// ttl_gate_bank: CHANNELS independent INPUTS-input gates with a shared function,
//   per-channel propagation-delay pipeline and rise/fall pulse outputs.
//   Optional glitch filter enabled by `define TTL_GLITCH_FILTER_EN.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   ce    : clock enable for the delay pipelines
//   in    : gate inputs, in[c][i]
//   y     : registered gate outputs, one per channel
//   rise  : one-cycle pulse per channel after y goes 0->1
//   fall  : one-cycle pulse per channel after y goes 1->0
module ttl_gate_bank
  import ttl_pkg::*;
#(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned INPUTS     = 3,
  parameter gate_func_t  FUNC       = GATE_NOR,
  parameter int unsigned DELAY      = 1,
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ce,
  input  logic [CHANNELS-1:0][INPUTS-1:0]  in,
  output logic [CHANNELS-1:0]              y,
  output logic [CHANNELS-1:0]              rise,
  output logic [CHANNELS-1:0]              fall
);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("ttl_gate_bank: CHANNELS out of range 1..16");
  end
  if (INPUTS < 2 || INPUTS > MaxInputs) begin : g_bad_inputs
    $error("ttl_gate_bank: INPUTS out of range 2..8");
  end

  localparam logic PadVal   = gate_pad_val(FUNC);
  localparam logic ResetVal = gate_reset_val(FUNC);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [MaxInputs-1:0] vec;
    logic                 raw;

    always_comb begin
      vec              = {MaxInputs{PadVal}};
      vec[INPUTS-1:0]  = in[c];
      raw              = gate_eval(FUNC, vec);
    end

    ttl_delay_line #(
      .DELAY      (DELAY),
      .FILTER_LEN (FILTER_LEN),
      .RESET_VAL  (ResetVal)
    ) u_line (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .raw   (raw),
      .y     (y[c]),
      .rise  (rise[c]),
      .fall  (fall[c])
    );
  end

endmodule

// File: tb/tb_ttl_gate_bank.sv
// Testbench for ttl_gate_bank. Several instances with different parameters share
// clk, reset and ce; each has its own inputs. Filter checks are compiled only
// when TTL_GLITCH_FILTER_EN is defined.
module tb_ttl_gate_bank;
  import ttl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0][2:0] in_nor, in_and, in_ce, in_mid, in_xnor3;
  logic [0:0][3:0] in_xor;
  logic [1:0][1:0] in_nand;
  logic [0:0][1:0] in_flt;

  logic [2:0] y_nor, rise_nor, fall_nor;
  logic [2:0] y_and, rise_and, fall_and;
  logic [2:0] y_ce, rise_ce, fall_ce;
  logic [2:0] y_mid, rise_mid, fall_mid;
  logic [2:0] y_xnor, rise_xnor, fall_xnor;
  logic [0:0] y_xor, rise_xor, fall_xor;
  logic [1:0] y_nand, rise_nand, fall_nand;
  logic [0:0] y_flt, rise_flt, fall_flt;

  always #5 clk = ~clk;

  ttl_gate_bank #(.CHANNELS(3), .INPUTS(3), .FUNC(GATE_NOR), .DELAY(3)) u_nor (
    .clk(clk), .reset(reset), .ce(ce), .in(in_nor), .y(y_nor), .rise(rise_nor), .fall(fall_nor));
  ttl_gate_bank #(.CHANNELS(3), .INPUTS(3), .FUNC(GATE_AND), .DELAY(3)) u_and (
    .clk(clk), .reset(reset), .ce(ce), .in(in_and), .y(y_and), .rise(rise_and), .fall(fall_and));
  ttl_gate_bank #(.CHANNELS(3), .INPUTS(3), .FUNC(GATE_NOR), .DELAY(2)) u_ce (
    .clk(clk), .reset(reset), .ce(ce), .in(in_ce), .y(y_ce), .rise(rise_ce), .fall(fall_ce));
  ttl_gate_bank #(.CHANNELS(3), .INPUTS(3), .FUNC(GATE_NOR), .DELAY(4)) u_mid (
    .clk(clk), .reset(reset), .ce(ce), .in(in_mid), .y(y_mid), .rise(rise_mid), .fall(fall_mid));
  ttl_gate_bank #(.CHANNELS(3), .INPUTS(3), .FUNC(GATE_XNOR), .DELAY(1)) u_xnor (
    .clk(clk), .reset(reset), .ce(ce), .in(in_xnor3), .y(y_xnor), .rise(rise_xnor),
    .fall(fall_xnor));
  ttl_gate_bank #(.CHANNELS(1), .INPUTS(4), .FUNC(GATE_XOR), .DELAY(1)) u_xor (
    .clk(clk), .reset(reset), .ce(ce), .in(in_xor), .y(y_xor), .rise(rise_xor), .fall(fall_xor));
  ttl_gate_bank #(.CHANNELS(2), .INPUTS(2), .FUNC(GATE_NAND), .DELAY(1)) u_nand (
    .clk(clk), .reset(reset), .ce(ce), .in(in_nand), .y(y_nand), .rise(rise_nand),
    .fall(fall_nand));
  ttl_gate_bank #(.CHANNELS(1), .INPUTS(2), .FUNC(GATE_OR), .DELAY(1), .FILTER_LEN(3)) u_flt (
    .clk(clk), .reset(reset), .ce(ce), .in(in_flt), .y(y_flt), .rise(rise_flt), .fall(fall_flt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b1;
    in_nor = '0; in_and = '0; in_ce = '0; in_mid = '0; in_xnor3 = '0;
    in_xor = '0; in_nand = '0; in_flt = '0;
    tick();
    tick();
    n_checks++; if (y_nor !== 3'b111) begin
      n_fail++; $display("FAIL reset_nor_y got %b exp %b", y_nor, 3'b111); end
    n_checks++; if ((rise_nor | fall_nor) !== 3'b000) begin
      n_fail++; $display("FAIL reset_nor_pulses got r=%b f=%b exp 000", rise_nor, fall_nor); end
    n_checks++; if (y_and !== 3'b000) begin
      n_fail++; $display("FAIL reset_and_y got %b exp %b", y_and, 3'b000); end
    n_checks++; if (y_xor !== 1'b0) begin
      n_fail++; $display("FAIL reset_xor_y got %b exp 0", y_xor); end
    n_checks++; if (y_nand !== 2'b11) begin
      n_fail++; $display("FAIL reset_nand_y got %b exp 11", y_nand); end
    n_checks++; if (y_xnor !== 3'b111) begin
      n_fail++; $display("FAIL reset_xnor_y got %b exp 111", y_xnor); end
    reset = 1'b0;
    tick();
    n_checks++; if (y_nor !== 3'b111 || rise_nor !== 3'b000 || fall_nor !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_nor got y=%b r=%b f=%b exp 111/000/000",
                         y_nor, rise_nor, fall_nor); end
  endtask

  task automatic test_latency();
    in_nor[0][1] = 1'b1;  // raw[0] -> 0
    tick();  // edge 0
    n_checks++; if (y_nor !== 3'b111) begin
      n_fail++; $display("FAIL latency_e0_y got %b exp 111", y_nor); end
    tick();  // edge 1
    n_checks++; if (y_nor !== 3'b111) begin
      n_fail++; $display("FAIL latency_e1_y got %b exp 111", y_nor); end
    tick();  // edge 2
    n_checks++; if (y_nor !== 3'b110) begin
      n_fail++; $display("FAIL latency_e2_y got %b exp 110", y_nor); end
    n_checks++; if (fall_nor !== 3'b000) begin
      n_fail++; $display("FAIL latency_e2_fall got %b exp 000", fall_nor); end
    tick();  // edge 3
    n_checks++; if (fall_nor !== 3'b001 || rise_nor !== 3'b000) begin
      n_fail++; $display("FAIL latency_e3_pulse got f=%b r=%b exp 001/000", fall_nor, rise_nor); end
    tick();  // edge 4
    n_checks++; if (fall_nor !== 3'b000 || y_nor !== 3'b110) begin
      n_fail++; $display("FAIL latency_e4 got f=%b y=%b exp 000/110", fall_nor, y_nor); end
  endtask

  task automatic test_clock_enable();
    in_ce[2][0] = 1'b1;  // raw[2] -> 0
    ce = 1'b1; tick();   // A: stage0 loads
    n_checks++; if (y_ce !== 3'b111) begin
      n_fail++; $display("FAIL ce_a_y got %b exp 111", y_ce); end
    ce = 1'b0; tick();   // B: hold
    n_checks++; if (y_ce !== 3'b111) begin
      n_fail++; $display("FAIL ce_b_y got %b exp 111", y_ce); end
    ce = 1'b1; tick();   // C: stage1 loads -> y changes
    n_checks++; if (y_ce !== 3'b011 || fall_ce !== 3'b000) begin
      n_fail++; $display("FAIL ce_c got y=%b f=%b exp 011/000", y_ce, fall_ce); end
    ce = 1'b0; tick();   // D: pulse appears regardless of ce
    n_checks++; if (fall_ce !== 3'b100 || rise_ce !== 3'b000) begin
      n_fail++; $display("FAIL ce_d_pulse got f=%b r=%b exp 100/000", fall_ce, rise_ce); end
    ce = 1'b1; tick();   // E: pulse gone
    n_checks++; if (fall_ce !== 3'b000 || y_ce !== 3'b011) begin
      n_fail++; $display("FAIL ce_e got f=%b y=%b exp 000/011", fall_ce, y_ce); end
  endtask

  task automatic test_functions();
    in_xor[0] = 4'b0111;
    tick();
    n_checks++; if (y_xor !== 1'b1 || rise_xor !== 1'b0) begin
      n_fail++; $display("FAIL xor_0111 got y=%b r=%b exp 1/0", y_xor, rise_xor); end
    in_xor[0] = 4'b1111;
    tick();
    n_checks++; if (y_xor !== 1'b0 || rise_xor !== 1'b1 || fall_xor !== 1'b0) begin
      n_fail++; $display("FAIL xor_1111 got y=%b r=%b f=%b exp 0/1/0", y_xor, rise_xor, fall_xor); end
    in_xor[0] = 4'b1000;
    tick();
    n_checks++; if (y_xor !== 1'b1 || fall_xor !== 1'b1 || rise_xor !== 1'b0) begin
      n_fail++; $display("FAIL xor_1000 got y=%b r=%b f=%b exp 1/0/1", y_xor, rise_xor, fall_xor); end
    in_nand[0] = 2'b11; in_nand[1] = 2'b01;
    in_xnor3[0] = 3'b011; in_xnor3[1] = 3'b111; in_xnor3[2] = 3'b100;
    tick();
    n_checks++; if (y_nand !== 2'b10) begin
      n_fail++; $display("FAIL nand_vec got %b exp 10", y_nand); end
    n_checks++; if (y_xnor !== 3'b001) begin
      n_fail++; $display("FAIL xnor_vec got %b exp 001", y_xnor); end
    in_nand[0] = 2'b10; in_nand[1] = 2'b11;
    tick();
    n_checks++; if (y_nand !== 2'b01) begin
      n_fail++; $display("FAIL nand_vec2 got %b exp 01", y_nand); end
  endtask

  task automatic test_reset_mid_flight();
    in_mid[1][2] = 1'b1;  // raw[1] -> 0
    tick();
    tick();
    reset  = 1'b1;
    in_mid = '0;
    tick();
    n_checks++; if (y_mid !== 3'b111 || rise_mid !== 3'b000 || fall_mid !== 3'b000) begin
      n_fail++; $display("FAIL midrst_reset got y=%b r=%b f=%b exp 111/000/000",
                         y_mid, rise_mid, fall_mid); end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++; if (y_mid !== 3'b111 || rise_mid !== 3'b000 || fall_mid !== 3'b000) begin
        n_fail++; $display("FAIL midrst_after_%0d got y=%b r=%b f=%b exp 111/000/000",
                           k, y_mid, rise_mid, fall_mid); end
    end
  endtask

`ifdef TTL_GLITCH_FILTER_EN
  task automatic test_filter();
    in_flt[0] = 2'b01;
    tick();
    tick();
    in_flt[0] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (y_flt !== 1'b0 || rise_flt !== 1'b0 || fall_flt !== 1'b0) begin
        n_fail++; $display("FAIL filt_short_%0d got y=%b r=%b f=%b exp 0/0/0",
                           k, y_flt, rise_flt, fall_flt); end
    end
    in_flt[0] = 2'b10;
    tick();
    tick();
    n_checks++; if (y_flt !== 1'b0) begin
      n_fail++; $display("FAIL filt_e1 got %b exp 0", y_flt); end
    tick();  // third mismatch
    n_checks++; if (y_flt !== 1'b1) begin
      n_fail++; $display("FAIL filt_e2 got %b exp 1", y_flt); end
    in_flt[0] = 2'b00;
    tick();
    n_checks++; if (y_flt !== 1'b1 || rise_flt !== 1'b1) begin
      n_fail++; $display("FAIL filt_e3 got y=%b r=%b exp 1/1", y_flt, rise_flt); end
    tick();
    n_checks++; if (y_flt !== 1'b1) begin
      n_fail++; $display("FAIL filt_e4 got %b exp 1", y_flt); end
    tick();
    n_checks++; if (y_flt !== 1'b0) begin
      n_fail++; $display("FAIL filt_e5 got %b exp 0", y_flt); end
    tick();
    n_checks++; if (fall_flt !== 1'b1) begin
      n_fail++; $display("FAIL filt_e6_fall got %b exp 1", fall_flt); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_clock_enable();
    test_functions();
    test_reset_mid_flight();
`ifdef TTL_GLITCH_FILTER_EN
    test_filter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
